gpio_cmd_rx: RTL

- Host-to-board counterpart of the GPIO event reporter. It parses GPIO command frames arriving on the master-side byte bus (frame_valid / data_latch framing, same byte layout as outgoing GPIO event frames).
- Drives the gpio_level and gpio_direction registers that feed the GPIO pin drivers.
- Each parsed command is committed atomically at end of frame and acknowledged with an ack or nak pulse.

---
 rtl/gpio_pkg.sv | 53 +++++
 rtl/gpio_cmd_shadow.sv | 38 +++
 rtl/gpio_cmd_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: frame constants, FSM states and param decode shared
// by the GPIO command receiver and the GPIO event reporter.
package gpio_pkg;

  localparam logic [7:0] GPIO_CMD_ID = 8'h67;
  localparam logic [7:0] PARAM_LEVEL = 8'h6c;
  localparam logic [7:0] PARAM_DIR   = 8'h64;
  localparam logic [7:0] PARAM_SET   = 8'h73;
  localparam logic [7:0] PARAM_CLR   = 8'h63;

  localparam logic [7:0] PAYLOAD_LEN = 8'd4;
  localparam logic [2:0] DATA_BYTES  = 3'd3;
  localparam int         SHADOW_W    = 24;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_EVT,
    S_LEN,
    S_PARAM,
    S_DATA,
    S_IGNORE
  } rx_state_e;

  typedef enum logic [1:0] {
    OP_LEVEL,
    OP_DIR,
    OP_SET,
    OP_CLR
  } gpio_op_e;

  typedef struct packed {
    logic     ok;
    gpio_op_e op;
  } param_dec_t;

  function automatic param_dec_t decode_param(
    input logic [7:0] code
  );
    param_dec_t d;
    d.ok = 1'b1;
    d.op = OP_LEVEL;
    unique case (1'b1)
      code == PARAM_LEVEL: d.op = OP_LEVEL;
      code == PARAM_DIR:   d.op = OP_DIR;
      code == PARAM_SET:   d.op = OP_SET;
      code == PARAM_CLR:   d.op = OP_CLR;
      default:             d.ok = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gpio_cmd_shadow.sv
// gpio_cmd_shadow: payload shift-in register with a saturating
// byte counter and an overflow flag for oversize frames.
module gpio_cmd_shadow
  import gpio_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                shift,
  input  logic [7:0]          data,
  output logic [SHADOW_W-1:0] value,
  output logic [2:0]          count,
  output logic                overflow
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      value    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (shift) begin
      // a full payload is frozen; extra bytes only flag overflow
      if (count >= DATA_BYTES) begin
        overflow <= 1'b1;
      end else begin
        value <= {value[SHADOW_W-9:0], data};
      end
      if (count != 3'd7) begin
        count <= count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/gpio_cmd_rx.sv
// gpio_cmd_rx: parses host GPIO command frames and commits level
// and direction updates atomically at end of frame.
module gpio_cmd_rx
  import gpio_pkg::*;
#(
  parameter int         GPIO_WIDTH = 24,
  parameter logic [7:0] CMD_ID     = GPIO_CMD_ID
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_frame_valid,
  input  logic                  in_data_latch,
  output logic [GPIO_WIDTH-1:0] gpio_level,
  output logic [GPIO_WIDTH-1:0] gpio_direction,
  output logic                  cmd_ack,
  output logic                  cmd_nak,
  output logic [7:0]            cmd_event_id
);

  rx_state_e     state;
  logic          len_ok;
  logic          param_ok;
  gpio_op_e      op;
  param_dec_t    dec;

  logic                  latch;
  logic                  frame_end;
  logic                  busy;
  logic                  commit;
  logic                  sh_clear;
  logic                  sh_shift;
  logic [SHADOW_W-1:0]   sh_value;
  logic [2:0]            sh_count;
  logic                  sh_ovf;
  logic [GPIO_WIDTH-1:0] pdata;

  assign latch     = in_frame_valid & in_data_latch;
  assign frame_end = ~in_frame_valid;
  assign dec       = decode_param(in_data);
  assign pdata     = sh_value[GPIO_WIDTH-1:0];

  // EVT..DATA are only reachable with valid high, so a low
  // sample there is exactly the 1-then-0 frame end
  assign busy = (state == S_EVT)   ||
                (state == S_LEN)   ||
                (state == S_PARAM) ||
                (state == S_DATA);

  assign commit = (state == S_DATA)       &&
                  (sh_count == DATA_BYTES) &&
                  !sh_ovf && len_ok && param_ok;

  assign sh_clear = (state == S_IDLE);
  assign sh_shift = (state == S_DATA) & latch;

  gpio_cmd_shadow u_shadow (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (sh_clear),
    .shift    (sh_shift),
    .data     (in_data),
    .value    (sh_value),
    .count    (sh_count),
    .overflow (sh_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_WAIT_IDLE;
      gpio_level     <= '0;
      gpio_direction <= '0;
      cmd_ack        <= 1'b0;
      cmd_nak        <= 1'b0;
      cmd_event_id   <= '0;
      len_ok         <= 1'b0;
      param_ok       <= 1'b0;
      op             <= OP_LEVEL;
    end else begin
      cmd_ack <= 1'b0;
      cmd_nak <= 1'b0;
      if (busy && frame_end) begin
        state <= S_IDLE;
        if (commit) begin
          cmd_ack <= 1'b1;
          unique case (op)
            OP_LEVEL: gpio_level <= pdata;
            OP_DIR:   gpio_direction <= pdata;
            OP_SET:   gpio_level <= gpio_level | pdata;
            OP_CLR:   gpio_level <= gpio_level & ~pdata;
          endcase
        end else begin
          cmd_nak <= 1'b1;
        end
      end else begin
        unique case (state)
          S_WAIT_IDLE: begin
            if (frame_end) state <= S_IDLE;
          end
          S_IDLE: begin
            len_ok   <= 1'b0;
            param_ok <= 1'b0;
            if (latch) begin
              state <= (in_data == CMD_ID) ?
                       S_EVT : S_IGNORE;
            end
          end
          S_EVT: begin
            if (latch) begin
              cmd_event_id <= in_data;
              state        <= S_LEN;
            end
          end
          S_LEN: begin
            if (latch) begin
              len_ok <= (in_data == PAYLOAD_LEN);
              state  <= S_PARAM;
            end
          end
          S_PARAM: begin
            if (latch) begin
              param_ok <= dec.ok;
              op       <= dec.op;
              state    <= S_DATA;
            end
          end
          S_DATA: begin
            state <= S_DATA;
          end
          S_IGNORE: begin
            if (frame_end) state <= S_IDLE;
          end
          default: state <= S_WAIT_IDLE;
        endcase
      end
    end
  end

endmodule
